// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N request/response channel pairs share one slave memory port.
// Arbitration is fixed-priority or round-robin. A grant is held while the slave
// stalls, and each master has a cap on outstanding requests. An in-order tag FIFO
// records which master issued each request, so slave responses go back to it.
module mem_arbiter_rr #(
    parameter int CNT            = 2,
    parameter int QUEUE_DEPTH    = 4,
    parameter int MAX_PER_MASTER = 2,
    parameter int RR             = 0,
    parameter int REQ_W          = 32,
    parameter int RESP_W         = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [CNT-1:0]                     master_req_valid_i,
    input  logic [CNT-1:0][REQ_W-1:0]          master_req_data_i,
    output logic [CNT-1:0]                     master_req_ready_o,
    output logic [CNT-1:0]                     master_resp_valid_o,
    output logic [CNT-1:0][RESP_W-1:0]         master_resp_data_o,
    input  logic [CNT-1:0]                     master_resp_ready_i,
    output logic                               slave_req_valid_o,
    output logic [REQ_W-1:0]                   slave_req_data_o,
    input  logic                               slave_req_ready_i,
    input  logic                               slave_resp_valid_i,
    input  logic [RESP_W-1:0]                  slave_resp_data_i,
    output logic                               slave_resp_ready_o,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   outstanding_o,
    output logic                               idle_o
);

    localparam int IW = $clog2(CNT);
    localparam int PW = $clog2(MAX_PER_MASTER + 1);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

    localparam logic [CW-1:0] DEPTH_C   = CW'(QUEUE_DEPTH);
    localparam logic [PW-1:0] MAX_C     = PW'(MAX_PER_MASTER);
    localparam logic [AW-1:0] LAST_SLOT = AW'(QUEUE_DEPTH - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(CNT - 1);

    typedef enum logic {
        ARB_OPEN,
        ARB_HELD
    } arb_state_e;

    // Registered state
    arb_state_e         arb_state_q, arb_state_d;
    logic [IW-1:0]      lock_idx_q, lock_idx_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      fifo_q [QUEUE_DEPTH];
    logic [AW-1:0]      rd_q, rd_d;
    logic [AW-1:0]      wr_q, wr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]      pend_q [CNT];
    logic [PW-1:0]      pend_d [CNT];

    // Combinational arbitration / routing
    logic [CNT-1:0]     elig;
    logic [IW-1:0]      pick;
    logic               pick_found;
    logic [IW-1:0]      sel;
    logic               cand_valid;
    logic               fifo_empty;
    logic               fifo_full;
    logic [IW-1:0]      fifo_head;
    logic               pop_stored;
    logic               req_hs;
    logic               resp_avail;
    logic [IW-1:0]      head;
    logic               resp_hs;

    // Eligibility: master is requesting and still below its outstanding cap
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < CNT; i++) begin
            elig[i] = master_req_valid_i[i] && (pend_q[i] < MAX_C);
        end
    end

    // Winner search: lowest index (fixed) or first eligible after ptr (round-robin)
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        if (RR != 0) begin
            for (int unsigned off = 1; off <= CNT; off++) begin
                logic [IW-1:0] cand;
                cand = IW'((32'(ptr_q) + off) % CNT);
                if (!pick_found && elig[cand]) begin
                    pick       = cand;
                    pick_found = 1'b1;
                end
            end
        end else begin
            for (int unsigned i = 0; i < CNT; i++) begin
                if (!pick_found && elig[i]) begin
                    pick       = IW'(i);
                    pick_found = 1'b1;
                end
            end
        end
    end

    // Request muxing, response routing and handshake detection.
    // The full-FIFO bypass only looks at a pop of an already-stored tag; a
    // fallthrough pop can only happen with an empty FIFO, which is never full,
    // so this ordering avoids a combinational loop without changing behaviour.
    always_comb begin
        sel        = (arb_state_q == ARB_HELD) ? lock_idx_q : pick;
        cand_valid = (arb_state_q == ARB_HELD) ? master_req_valid_i[lock_idx_q] : pick_found;

        fifo_empty = (cnt_q == '0);
        fifo_full  = (cnt_q == DEPTH_C);
        fifo_head  = fifo_q[rd_q];

        pop_stored = !fifo_empty && slave_resp_valid_i
                     && master_resp_ready_i[fifo_head] && !rst;

        slave_req_valid_o = cand_valid && (!fifo_full || pop_stored) && !rst;
        slave_req_data_o  = master_req_data_i[sel];
        req_hs            = slave_req_valid_o && slave_req_ready_i;

        resp_avail = !fifo_empty || req_hs;
        head       = fifo_empty ? sel : fifo_head;

        slave_resp_ready_o = resp_avail && master_resp_ready_i[head] && !rst;
        resp_hs            = slave_resp_ready_o && slave_resp_valid_i;

        master_req_ready_o  = '0;
        master_resp_valid_o = '0;
        for (int unsigned i = 0; i < CNT; i++) begin
            master_req_ready_o[i]  = req_hs && (sel == IW'(i));
            master_resp_valid_o[i] = slave_resp_valid_i && resp_avail && (head == IW'(i));
            master_resp_data_o[i]  = slave_resp_data_i;
        end

        outstanding_o = cnt_q;
        idle_o        = (cnt_q == '0) && !(|master_req_valid_i);
    end

    // Grant-lock FSM: hold the current winner while the slave stalls it
    always_comb begin
        arb_state_d = arb_state_q;
        lock_idx_d  = lock_idx_q;
        case (arb_state_q)
            ARB_OPEN: begin
                if (slave_req_valid_o && !slave_req_ready_i) begin
                    arb_state_d = ARB_HELD;
                    lock_idx_d  = sel;
                end
            end
            ARB_HELD: begin
                if (!slave_req_valid_o || slave_req_ready_i) begin
                    arb_state_d = ARB_OPEN;
                end
            end
            default: begin
                arb_state_d = ARB_OPEN;
            end
        endcase
    end

    // Next state for FIFO pointers, occupancy, per-master counts and RR pointer
    always_comb begin
        cnt_d = cnt_q + CW'(req_hs) - CW'(resp_hs);

        wr_d = wr_q;
        if (req_hs) begin
            wr_d = (wr_q == LAST_SLOT) ? '0 : wr_q + AW'(1);
        end

        rd_d = rd_q;
        if (resp_hs) begin
            rd_d = (rd_q == LAST_SLOT) ? '0 : rd_q + AW'(1);
        end

        for (int unsigned i = 0; i < CNT; i++) begin
            pend_d[i] = pend_q[i]
                        + PW'(req_hs && (sel == IW'(i)))
                        - PW'(resp_hs && (head == IW'(i)));
        end

        ptr_d = ptr_q;
        if ((RR != 0) && req_hs) begin
            ptr_d = sel;
        end
    end

    // State registers; reset empties the FIFO and restarts RR at master 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arb_state_q <= ARB_OPEN;
            lock_idx_q  <= '0;
            ptr_q       <= LAST_IDX;
            rd_q        <= '0;
            wr_q        <= '0;
            cnt_q       <= '0;
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            for (int unsigned i = 0; i < CNT; i++) begin
                pend_q[i] <= '0;
            end
        end else begin
            arb_state_q <= arb_state_d;
            lock_idx_q  <= lock_idx_d;
            ptr_q       <= ptr_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            if (req_hs) begin
                fifo_q[wr_q] <= sel;
            end
            for (int unsigned i = 0; i < CNT; i++) begin
                pend_q[i] <= pend_d[i];
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Scoreboard bench for mem_arbiter_rr: two instances (fixed priority with a
// 2-deep FIFO, round-robin with 3 masters). Stimulus pushes expected grants and
// responses; per-instance monitors pop and compare on each handshake.
module tb_mem_arbiter_rr;

    typedef struct packed {
        logic [7:0]  m;
        logic [15:0] d;
    } rsp_t;

    logic clk;
    logic rst_a, rst_b;

    // Instance A: CNT=2, QUEUE_DEPTH=2, fixed priority
    logic [1:0]        a_mreq_v, a_mreq_r, a_mresp_v, a_mresp_r;
    logic [1:0][15:0]  a_mreq_d, a_mresp_d;
    logic              a_sreq_v, a_sreq_r, a_sresp_v, a_sresp_r, a_idle;
    logic [15:0]       a_sreq_d, a_sresp_d;
    logic [1:0]        a_out;

    // Instance B: CNT=3, QUEUE_DEPTH=4, round-robin
    logic [2:0]        b_mreq_v, b_mreq_r, b_mresp_v, b_mresp_r;
    logic [2:0][15:0]  b_mreq_d, b_mresp_d;
    logic              b_sreq_v, b_sreq_r, b_sresp_v, b_sresp_r, b_idle;
    logic [15:0]       b_sreq_d, b_sresp_d;
    logic [2:0]        b_out;

    int n_pass  = 0;
    int n_total = 0;

    int   qa_g[$];
    int   qb_g[$];
    rsp_t qa_r[$];
    rsp_t qb_r[$];

    mem_arbiter_rr #(.CNT(2), .QUEUE_DEPTH(2), .MAX_PER_MASTER(2), .RR(0),
                     .REQ_W(16), .RESP_W(16)) u_a (
        .clk(clk), .rst(rst_a),
        .master_req_valid_i(a_mreq_v), .master_req_data_i(a_mreq_d),
        .master_req_ready_o(a_mreq_r),
        .master_resp_valid_o(a_mresp_v), .master_resp_data_o(a_mresp_d),
        .master_resp_ready_i(a_mresp_r),
        .slave_req_valid_o(a_sreq_v), .slave_req_data_o(a_sreq_d),
        .slave_req_ready_i(a_sreq_r),
        .slave_resp_valid_i(a_sresp_v), .slave_resp_data_i(a_sresp_d),
        .slave_resp_ready_o(a_sresp_r),
        .outstanding_o(a_out), .idle_o(a_idle)
    );

    mem_arbiter_rr #(.CNT(3), .QUEUE_DEPTH(4), .MAX_PER_MASTER(2), .RR(1),
                     .REQ_W(16), .RESP_W(16)) u_b (
        .clk(clk), .rst(rst_b),
        .master_req_valid_i(b_mreq_v), .master_req_data_i(b_mreq_d),
        .master_req_ready_o(b_mreq_r),
        .master_resp_valid_o(b_mresp_v), .master_resp_data_o(b_mresp_d),
        .master_resp_ready_i(b_mresp_r),
        .slave_req_valid_o(b_sreq_v), .slave_req_data_o(b_sreq_d),
        .slave_req_ready_i(b_sreq_r),
        .slave_resp_valid_i(b_sresp_v), .slave_resp_data_i(b_sresp_d),
        .slave_resp_ready_o(b_sresp_r),
        .outstanding_o(b_out), .idle_o(b_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endfunction

    function automatic rsp_t mk(input int m, input logic [15:0] d);
        rsp_t r;
        r.m = 8'(m);
        r.d = d;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor A: compare every request and response handshake with the scoreboard
    logic [1:0] a_em, a_rmask;
    int         a_m;
    rsp_t       a_rexp;
    always @(negedge clk) begin
        if (!rst_a) begin
            if (a_sreq_v && a_sreq_r) begin
                if (qa_g.size() == 0) begin
                    n_total++;
                    $display("FAIL a_grant_unexpected: got data %h, none expected", a_sreq_d);
                end else begin
                    a_m  = qa_g.pop_front();
                    a_em = 2'b01 << a_m;
                    chk("a_grant", 64'({a_mreq_r, a_sreq_d}), 64'({a_em, 16'hA000 + 16'(a_m)}));
                end
            end
            a_rmask = a_mresp_v & a_mresp_r;
            if (a_rmask != '0) begin
                if (qa_r.size() == 0) begin
                    n_total++;
                    $display("FAIL a_resp_unexpected: got mask %b data %h", a_rmask, a_sresp_d);
                end else begin
                    a_rexp = qa_r.pop_front();
                    a_em   = 2'b01 << a_rexp.m;
                    chk("a_resp", 64'({a_rmask, a_mresp_d[a_rexp.m]}), 64'({a_em, a_rexp.d}));
                end
            end
        end
    end

    // Monitor B: same scoreboard comparison for the round-robin instance
    logic [2:0] b_em, b_rmask;
    int         b_m;
    rsp_t       b_rexp;
    always @(negedge clk) begin
        if (!rst_b) begin
            if (b_sreq_v && b_sreq_r) begin
                if (qb_g.size() == 0) begin
                    n_total++;
                    $display("FAIL b_grant_unexpected: got data %h, none expected", b_sreq_d);
                end else begin
                    b_m  = qb_g.pop_front();
                    b_em = 3'b001 << b_m;
                    chk("b_grant", 64'({b_mreq_r, b_sreq_d}), 64'({b_em, 16'hA000 + 16'(b_m)}));
                end
            end
            b_rmask = b_mresp_v & b_mresp_r;
            if (b_rmask != '0) begin
                if (qb_r.size() == 0) begin
                    n_total++;
                    $display("FAIL b_resp_unexpected: got mask %b data %h", b_rmask, b_sresp_d);
                end else begin
                    b_rexp = qb_r.pop_front();
                    b_em   = 3'b001 << b_rexp.m;
                    chk("b_resp", 64'({b_rmask, b_mresp_d[b_rexp.m]}), 64'({b_em, b_rexp.d}));
                end
            end
        end
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        a_mreq_v = '0; a_mresp_r = '0; a_sreq_r = 1'b0; a_sresp_v = 1'b0; a_sresp_d = '0;
        b_mreq_v = '0; b_mresp_r = '0; b_sreq_r = 1'b0; b_sresp_v = 1'b0; b_sresp_d = '0;
        a_mreq_d[0] = 16'hA000; a_mreq_d[1] = 16'hA001;
        b_mreq_d[0] = 16'hA000; b_mreq_d[1] = 16'hA001; b_mreq_d[2] = 16'hA002;

        // Reset values, and reset gating of valid/ready with inputs active
        #2;
        chk("a_rst_sreq_v", 64'(a_sreq_v), 64'd0);
        chk("a_rst_out", 64'(a_out), 64'd0);
        chk("a_rst_idle", 64'(a_idle), 64'd1);
        a_mreq_v = 2'b11; a_sreq_r = 1'b1; a_sresp_v = 1'b1; a_mresp_r = 2'b11;
        #1;
        chk("a_rst_gate", 64'({a_sreq_v, a_mreq_r, a_sresp_r, a_mresp_v}), 64'd0);
        chk("a_rst_idle_busy", 64'(a_idle), 64'd0);
        a_mreq_v = '0; a_sresp_v = 1'b0; a_sreq_r = 1'b0;
        tick(); tick();
        rst_a = 1'b0; rst_b = 1'b0;

        // A1: fixed priority fills the 2-deep FIFO, then pop+push while full
        qa_g.push_back(0); qa_g.push_back(0);
        a_sreq_r = 1'b1; a_mreq_v = 2'b11;
        tick();
        tick();
        chk("a_full_sreq_v", 64'(a_sreq_v), 64'd0);
        chk("a_full_out", 64'(a_out), 64'd2);
        chk("a_full_mreq_r", 64'(a_mreq_r), 64'd0);
        tick();
        chk("a_full_hold", 64'(a_sreq_v), 64'd0);
        qa_g.push_back(1); qa_r.push_back(mk(0, 16'h5000));
        a_sresp_d = 16'h5000; a_sresp_v = 1'b1;
        #1;
        chk("a_full_pop_push", 64'({a_sreq_v, a_sreq_d, a_out}), 64'({1'b1, 16'hA001, 2'd2}));
        tick();
        chk("a_full_out_keep", 64'(a_out), 64'd2);
        a_mreq_v = '0; qa_r.push_back(mk(0, 16'h5001)); a_sresp_d = 16'h5001;
        tick();
        qa_r.push_back(mk(1, 16'h5002)); a_sresp_d = 16'h5002;
        tick();
        a_sresp_v = 1'b0;
        #1;
        chk("a_drain_out", 64'(a_out), 64'd0);
        chk("a_drain_idle", 64'(a_idle), 64'd1);

        // A2: grant lock on master 1 while the slave stalls for 3 cycles
        a_sreq_r = 1'b0; a_mreq_v = 2'b10;
        #1;
        chk("a_lock_first", 64'({a_sreq_v, a_sreq_d}), 64'({1'b1, 16'hA001}));
        tick();
        a_mreq_v = 2'b11;
        #1;
        chk("a_lock_hold", 64'({a_sreq_v, a_sreq_d, a_mreq_r}), 64'({1'b1, 16'hA001, 2'b00}));
        tick();
        chk("a_lock_hold2", 64'({a_sreq_v, a_sreq_d, a_mreq_r}), 64'({1'b1, 16'hA001, 2'b00}));
        tick();
        qa_g.push_back(1); qa_g.push_back(0);
        a_sreq_r = 1'b1;
        tick();
        chk("a_after_lock", 64'(a_sreq_d), 64'h0000_0000_0000_A000);
        tick();
        a_mreq_v = '0; a_sreq_r = 1'b0;
        // Head-of-line: master 1 not ready blocks all responses
        a_mresp_r = 2'b01; a_sresp_v = 1'b1; a_sresp_d = 16'h5003;
        #1;
        chk("a_hol_ready", 64'(a_sresp_r), 64'd0);
        chk("a_hol_valid", 64'(a_mresp_v), 64'd2);
        tick();
        qa_r.push_back(mk(1, 16'h5003)); a_mresp_r = 2'b11;
        tick();
        qa_r.push_back(mk(0, 16'h5004)); a_sresp_d = 16'h5004;
        tick();
        a_sresp_v = 1'b0;
        #1;
        chk("a_lock_drain_out", 64'(a_out), 64'd0);

        // A3: zero-latency slave on an empty FIFO
        qa_g.push_back(0); qa_r.push_back(mk(0, 16'h5005));
        a_mreq_v = 2'b01; a_sreq_r = 1'b1; a_sresp_v = 1'b1; a_sresp_d = 16'h5005;
        #1;
        chk("a_zl_resp_v", 64'(a_mresp_v), 64'd1);
        chk("a_zl_out", 64'(a_out), 64'd0);
        tick();
        a_mreq_v = '0;
        #1;
        chk("a_zl_out_after", 64'(a_out), 64'd0);
        chk("a_illegal_resp", 64'({a_sresp_r, a_mresp_v}), 64'd0);
        a_sresp_v = 1'b0; a_sreq_r = 1'b0;

        // B1: round-robin over 3 masters with immediate responses
        b_mreq_v = 3'b111; b_sreq_r = 1'b1; b_sresp_v = 1'b1; b_mresp_r = 3'b111;
        for (int k = 0; k < 6; k++) begin
            qb_g.push_back(k % 3);
            qb_r.push_back(mk(k % 3, 16'h6000 + 16'(k)));
            b_sresp_d = 16'h6000 + 16'(k);
            tick();
        end
        b_mreq_v = 3'b101;
        for (int k = 0; k < 4; k++) begin
            qb_g.push_back((k % 2 == 1) ? 2 : 0);
            qb_r.push_back(mk((k % 2 == 1) ? 2 : 0, 16'h6010 + 16'(k)));
            b_sresp_d = 16'h6010 + 16'(k);
            tick();
        end

        // B2: three outstanding, then asynchronous reset mid-operation
        b_mreq_v = 3'b011; b_sresp_v = 1'b0;
        qb_g.push_back(0); qb_g.push_back(1); qb_g.push_back(0);
        tick(); tick(); tick();
        chk("b_pre_rst_out", 64'(b_out), 64'd3);
        chk("b_pre_rst_v", 64'(b_sreq_v), 64'd1);
        rst_b = 1'b1;
        b_sresp_v = 1'b1;
        #1;
        chk("b_rst_async", 64'({b_sreq_v, b_mreq_r, b_sresp_r, b_mresp_v, b_out}), 64'd0);
        chk("b_rst_idle", 64'(b_idle), 64'd0);
        b_sresp_v = 1'b0;
        tick();
        b_mreq_v = '0;
        #1;
        chk("b_rst_idle_quiet", 64'(b_idle), 64'd1);
        rst_b = 1'b0;
        #1;
        chk("b_post_rst_out", 64'(b_out), 64'd0);
        tick();
        qb_g.push_back(0); b_mreq_v = 3'b111;
        tick();
        qb_g.push_back(0); b_mreq_v = 3'b001;
        tick();
        chk("b_post_rst_cap", 64'(b_sreq_v), 64'd0);
        chk("b_post_rst_out2", 64'(b_out), 64'd2);
        b_mreq_v = '0; b_sresp_v = 1'b1; b_sresp_d = 16'h7000;
        qb_r.push_back(mk(0, 16'h7000));
        tick();
        qb_r.push_back(mk(0, 16'h7001)); b_sresp_d = 16'h7001;
        tick();
        b_sresp_v = 1'b0;
        #1;
        chk("b_final_out", 64'(b_out), 64'd0);

        tick(); tick();
        chk("qa_g_left", 64'(qa_g.size()), 64'd0);
        chk("qa_r_left", 64'(qa_r.size()), 64'd0);
        chk("qb_g_left", 64'(qb_g.size()), 64'd0);
        chk("qb_r_left", 64'(qb_r.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_rr.md
# mem_arbiter_rr

Parametrised successor memory arbiter: N master request/response channel pairs share one slave memory port. Arbitration is fixed-priority or round-robin. Grants are held stable while the slave stalls, and per-master outstanding requests are capped. An internal in-order tag FIFO routes each slave response back to the master that issued the request. The block sits between the core's memory clients (fetch, LSU, PTW) and the single memory/bus port.

## Interface
Parameters:
- CNT, 2: number of masters. Must be at least 2.
- QUEUE_DEPTH, 4: total outstanding requests, i.e. tag FIFO depth. Must be at least 1.
- MAX_PER_MASTER, 2: outstanding-request cap per master, 1..QUEUE_DEPTH.
- RR, 0: 0 = fixed priority (lower index wins); 1 = round-robin.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Asynchronous, active-high.
- master_req[CNT]  decoupled.in  mreq  request from each master.
- master_resp[CNT]  decoupled.out  resp data  response to each master.
- slave_req  decoupled.out  mreq  arbitrated request.
- slave_resp  decoupled.in  resp data  in-order responses from the slave.
- outstanding  out  $clog2(QUEUE_DEPTH+1)  tag FIFO occupancy.
- idle  out  1  asserted when outstanding==0 and no master_req valid.

## Operation
- Eligibility: master i is eligible when master_req[i].valid is high and pend[i] < MAX_PER_MASTER.
- Selection, RR=0: lowest-index eligible master wins.
- Selection, RR=1: search starts at (ptr+1) mod CNT and wraps; the first eligible master wins.
- Grant lock: once slave_req.valid is high with sel=k and no handshake has occurred, sel stays k next cycle regardless of new higher-priority requests. Masters must keep valid and data stable until ready; lock releases on handshake.
- slave_req.valid = any eligible (or locked) master, AND tag FIFO not full, AND !rst.
- slave_req.data = master_req[sel].data.
- master_req[i].ready = slave_req.valid && slave_req.ready && sel==i.
- On a request handshake: push sel into the tag FIFO, increment pend[sel], and (RR=1) set ptr <= sel.
- Response routing: head = tag FIFO head.
  - master_resp[i].valid = slave_resp.valid && fifo non-empty && head==i.
  - master_resp[*].data = slave_resp.data.
  - slave_resp.ready = fifo non-empty && master_resp[head].ready && !rst.
- On a response handshake: pop the FIFO and decrement pend[head].
- Fallthrough: when the FIFO is empty and a request handshake happens this cycle, the pushed index is visible as head in the same cycle. A zero-latency slave may therefore complete request and response in one cycle.
- Simultaneous push and pop:
  - outstanding is unchanged. A full FIFO accepts a push in the same cycle as a pop.
  - If the same master handshakes both request and response, its pend is unchanged.
- Responses are never reordered. A stalled master_resp[head].ready blocks all responses (head-of-line), which is intended.

## Timing
- Arbitration and routing are combinational; there is no added latency. A request reaches the slave in the same cycle it is valid, if eligible.
- State elements:
  - tag FIFO storage plus read pointer, write pointer and count;
  - pend[CNT], each $clog2(MAX_PER_MASTER+1) bits;
  - ptr, $clog2(CNT) bits;
  - lock flag and locked index.
- FIFO pointers wrap modulo QUEUE_DEPTH. The count saturates logically at QUEUE_DEPTH: full blocks slave_req.valid, except when the same cycle also pops.
- Reset (asynchronous, while rst=1):
  - FIFO empty, pend all 0, lock cleared, ptr=CNT-1 (so master 0 is first in RR mode), outstanding=0.
  - slave_req.valid=0, all master_req.ready=0, slave_resp.ready=0, all master_resp.valid=0, idle=1 when no master is valid.
- Reset mid-operation discards all in-flight tags. Responses that arrive afterwards for pre-reset requests are the slave's responsibility to flush.
- Illegal use: slave_resp.valid with an empty FIFO is never acknowledged (ready=0).

## Test plan
- RR=0, masters 0 and 1 both valid continuously, slave always ready, 1-cycle response:
  - grants go 0,0,0… until master 0 hits pend=MAX_PER_MASTER=2;
  - master 1 is then granted on the cycle master 0 is capped;
  - responses return to the correct masters.
- RR=1, CNT=3, all valid, slave always ready, responses immediate:
  - grant sequence after reset is 0,1,2,0,1,2;
  - dropping master 1's valid gives 0,2,0,2.
- Grant lock: master 1 valid with slave_req.ready=0 for 3 cycles, master 0 raises valid in cycle 2:
  - sel stays 1;
  - the handshake happens for master 1 when ready rises;
  - master 0 is granted next cycle.
- Full FIFO, QUEUE_DEPTH=2, no responses:
  - after 2 handshakes slave_req.valid=0 and outstanding=2;
  - a response pop in the same cycle as a new valid request allows a push; outstanding stays 2.
- Zero-latency slave (slave_resp.valid in the same cycle as the request handshake, FIFO empty):
  - master_resp[sel].valid=1 in that cycle;
  - outstanding stays 0.
- Reset mid-operation: assert rst asynchronously with 3 outstanding:
  - outputs drop immediately to reset values;
  - after deassert, outstanding=0 and pend=0, and RR restarts at master 0.
